// File: rtl/keylock_ctrl.sv
// keylock_ctrl: keypad code-lock sequencer.
// Collects 4-digit entries, checks them against the stored password, runs the
// change-password and lockout flows and drives the 4-nibble display bus.
// Optional build macro: KEYLOCK_KEY_TIMEOUT_EN adds an entry inactivity timeout
// (clears a partial entry after ENTRY_TO_CYC idle cycles).
module keylock_ctrl #(
  parameter int          DIGITS       = 4,
  parameter logic [15:0] DEFAULT_PW   = 16'h1234,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCKOUT_CYC  = 25_000_000,
  parameter int          OPEN_CYC     = 125_000_000,
  parameter int          ENTRY_TO_CYC = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  keycode,
  input  logic        key_ready,
  output logic        unlock,
  output logic        alarm,
  output logic        err,
  output logic        pw_done,
  output logic [15:0] seg_data,
  output logic [2:0]  state_o
);
  localparam int MAX_AB = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int MAX_CY = (MAX_AB > ENTRY_TO_CYC) ? MAX_AB : ENTRY_TO_CYC;
  localparam int TW     = $clog2(MAX_CY);
  localparam int FW     = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LO_LAST   = TW'(LOCKOUT_CYC - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [2:0]    CNT_FULL  = 3'(DIGITS);

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_NEWPW   = 3'd3,
    S_CONFPW  = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t          state, nx;
  logic            ks1, ks2, ks3, kev;
  logic [4:0]      kcode;
  logic [15:0]     ebuf, pw, cand, seg_entry;
  logic [2:0]      cnt;
  logic [FW-1:0]   fail_cnt, fail_nx;
  logic [TW-1:0]   open_tmr, lo_tmr;
  logic            k_dig, k_ent, k_clr, k_chg, full, entry_st;
  logic            err_n, commit, take_cand, chk_pass, chk_fail, lo_done;
  logic            buf_push, buf_clr, tmo_hit;

  assign state_o  = state;
  assign k_dig    = kev && (kcode < 5'd10);
  assign k_ent    = kev && (kcode == 5'd10);
  assign k_clr    = kev && (kcode == 5'd11);
  assign k_chg    = kev && (kcode == 5'd12);
  assign full     = (cnt == CNT_FULL);
  assign entry_st = (state == S_LOCKED) || (state == S_NEWPW) || (state == S_CONFPW);
  assign fail_nx  = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

  // Two-flop synchronizer on the async strobe; its falling edge becomes a one-cycle kev
  always_ff @(posedge clk) begin
    if (rst) begin
      ks1   <= 1'b1;
      ks2   <= 1'b1;
      ks3   <= 1'b1;
      kev   <= 1'b0;
      kcode <= '0;
    end else begin
      ks1 <= key_ready;
      ks2 <= ks1;
      ks3 <= ks2;
      kev <= ks3 & ~ks2;
      if (ks3 & ~ks2) kcode <= keycode;
    end
  end

`ifdef KEYLOCK_KEY_TIMEOUT_EN
  localparam logic [TW-1:0] ENT_LAST = TW'(ENTRY_TO_CYC - 1);
  logic [TW-1:0] ent_tmr;
  // A key event on the expiry cycle takes precedence, so expiry requires !kev
  assign tmo_hit = entry_st && (cnt != 3'd0) && !kev && (ent_tmr == ENT_LAST);

  // Inactivity counter: runs only while a partial entry is pending
  always_ff @(posedge clk) begin
    if (rst || !entry_st || cnt == 3'd0 || kev || tmo_hit) ent_tmr <= '0;
    else                                                  ent_tmr <= ent_tmr + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and action decode for the sequencer
  always_comb begin
    nx        = state;
    err_n     = 1'b0;
    commit    = 1'b0;
    take_cand = 1'b0;
    chk_pass  = 1'b0;
    chk_fail  = 1'b0;
    lo_done   = 1'b0;
    buf_push  = entry_st && k_dig && !full;
    buf_clr   = entry_st && k_clr;
    case (state)
      S_LOCKED: begin
        if (k_ent) begin
          if (full) nx = S_CHECK;
          else      err_n = 1'b1;
        end
      end
      S_CHECK: begin
        if (ebuf == pw) begin
          chk_pass = 1'b1;
          nx       = S_OPEN;
        end else begin
          chk_fail = 1'b1;
          err_n    = 1'b1;
          nx       = (fail_nx == FAIL_MAX) ? S_LOCKOUT : S_LOCKED;
        end
      end
      S_OPEN: begin
        // Relock expiry beats a coincident key
        if (open_tmr == OPEN_LAST)  nx = S_LOCKED;
        else if (k_ent || k_clr)    nx = S_LOCKED;
        else if (k_chg)             nx = S_NEWPW;
      end
      S_NEWPW: begin
        if (k_ent) begin
          if (full) begin
            take_cand = 1'b1;
            nx        = S_CONFPW;
          end else begin
            err_n = 1'b1;
          end
        end else if (k_clr && cnt == 3'd0) begin
          nx = S_OPEN;
        end
      end
      S_CONFPW: begin
        if (k_ent) begin
          if (!full) begin
            err_n = 1'b1;
          end else if (ebuf == cand) begin
            commit = 1'b1;
            nx     = S_LOCKED;
          end else begin
            err_n = 1'b1;
            nx    = S_OPEN;
          end
        end else if (k_clr && cnt == 3'd0) begin
          nx = S_OPEN;
        end
      end
      S_LOCKOUT: begin
        if (lo_tmr == LO_LAST) begin
          lo_done = 1'b1;
          nx      = S_LOCKED;
        end
      end
      default: nx = S_LOCKED;
    endcase
    if (tmo_hit) begin
      buf_clr = 1'b1;
      err_n   = 1'b1;
      if (state != S_LOCKED) nx = S_OPEN;
    end
  end

  // Sequencer registers: state, entry buffer, passwords, fail count, timers, outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOCKED;
      pw       <= DEFAULT_PW;
      cand     <= '0;
      ebuf     <= '0;
      cnt      <= '0;
      fail_cnt <= '0;
      open_tmr <= '0;
      lo_tmr   <= '0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
      err      <= 1'b0;
      pw_done  <= 1'b0;
    end else begin
      state   <= nx;
      unlock  <= (nx == S_OPEN) || (nx == S_NEWPW) || (nx == S_CONFPW);
      alarm   <= (nx == S_LOCKOUT);
      err     <= err_n;
      pw_done <= commit;
      if (take_cand) cand <= ebuf;
      if (commit)    pw   <= cand;
      if (chk_pass || lo_done) fail_cnt <= '0;
      else if (chk_fail)       fail_cnt <= fail_nx;
      // Entry buffer empties on every state change, except into CHECK which compares it
      if ((nx != state && nx != S_CHECK) || buf_clr) begin
        ebuf <= '0;
        cnt  <= '0;
      end else if (buf_push) begin
        ebuf <= {ebuf[11:0], kcode[3:0]};
        cnt  <= cnt + 3'd1;
      end
      // Relock timer holds its value across NEWPW/CONFPW and restarts once unlock drops
      if (state == S_OPEN && nx == S_OPEN)
        open_tmr <= open_tmr + TW'(1);
      else if (nx != S_OPEN && nx != S_NEWPW && nx != S_CONFPW)
        open_tmr <= '0;
      if (state == S_LOCKOUT && nx == S_LOCKOUT) lo_tmr <= lo_tmr + TW'(1);
      else                                       lo_tmr <= '0;
    end
  end

  // Right-to-left entry image: masked digits when locked, real digits when changing
  always_comb begin
    seg_entry = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < cnt)
        seg_entry[4*i +: 4] = (state == S_NEWPW || state == S_CONFPW) ? ebuf[4*i +: 4] : 4'hA;
    end
  end

  // Display bus register, one cycle behind state and buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_data <= 16'hFFFF;
    end else begin
      case (state)
        S_OPEN:    seg_data <= 16'hBBBB;
        S_LOCKOUT: seg_data <= 16'hEEEE;
        default:   seg_data <= seg_entry;
      endcase
    end
  end

endmodule

// File: tb/tb_keylock_ctrl.sv
// tb_keylock_ctrl: directed key sequences; expected output events go into a
// queue and a monitor compares every change of the observable outputs in order.
module tb_keylock_ctrl;
  localparam int LOCKOUT_CYC = 60;
  localparam int OPEN_CYC    = 400;
  localparam logic [2:0] LOCKED = 3'd0, CHECK = 3'd1, OPEN = 3'd2,
                         NEWPW = 3'd3, CONFPW = 3'd4, LOCKOUT = 3'd5;
  localparam logic [4:0] ENT = 5'd10, CLR = 5'd11, CHG = 5'd12;

  logic        clk = 1'b0, rst = 1'b1, key_ready = 1'b1;
  logic [4:0]  keycode = '0;
  logic        unlock, alarm, err, pw_done;
  logic [15:0] seg_data;
  logic [2:0]  state_o;

  int          checks = 0, fails = 0;
  logic [22:0] expq[$];
  logic        mon_en = 1'b0;
  int          last_open_run = 0;

  always #5 clk = ~clk;

  keylock_ctrl #(
    .DIGITS(4), .DEFAULT_PW(16'h1234), .MAX_FAIL(3),
    .LOCKOUT_CYC(LOCKOUT_CYC), .OPEN_CYC(OPEN_CYC), .ENTRY_TO_CYC(1000)
  ) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .key_ready(key_ready),
    .unlock(unlock), .alarm(alarm), .err(err), .pw_done(pw_done),
    .seg_data(seg_data), .state_o(state_o)
  );

  function automatic logic [22:0] mk(input logic [2:0] st, input logic [15:0] seg,
                                     input logic e, input logic p);
    logic ul;
    ul = (st == OPEN) || (st == NEWPW) || (st == CONFPW);
    mk = {st, ul, (st == LOCKOUT), e, p, seg};
  endfunction

  function automatic logic [22:0] obs();
    obs = {state_o, unlock, alarm, err, pw_done, seg_data};
  endfunction

  function automatic string fmt(input logic [22:0] v);
    fmt = $sformatf("st=%0d unl=%b alm=%b err=%b pwd=%b seg=%h",
                    v[22:20], v[19], v[18], v[17], v[16], v[15:0]);
  endfunction

  task automatic ex(input logic [2:0] st, input logic [15:0] seg,
                    input logic e = 1'b0, input logic p = 1'b0);
    expq.push_back(mk(st, seg, e, p));
  endtask

  task automatic press(input logic [4:0] c);
    @(posedge clk); #1;
    keycode   = c;
    key_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 key_ready = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Four digits in LOCKED: display shows one more mask nibble per digit
  task automatic lock_digits(input logic [15:0] code);
    logic [15:0] mt [4] = '{16'hFFFA, 16'hFFAA, 16'hFAAA, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      ex(LOCKED, mt[i]);
      press({1'b0, code[15-4*i -: 4]});
    end
  endtask

  // Four digits in NEWPW/CONFPW: display shows the digits right-aligned
  task automatic pw_digits(input logic [15:0] code, input logic [2:0] st);
    logic [15:0] shown;
    shown = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      shown = {shown[11:0], code[15-4*i -: 4]};
      ex(st, shown);
      press({1'b0, code[15-4*i -: 4]});
    end
  endtask

  task automatic enter_ok(input logic [15:0] code);
    lock_digits(code);
    ex(CHECK, 16'hAAAA);
    ex(OPEN, 16'hAAAA);
    ex(OPEN, 16'hBBBB);
    press(ENT);
  endtask

  task automatic enter_bad(input logic [15:0] code, input logic last);
    lock_digits(code);
    ex(CHECK, 16'hAAAA);
    ex(last ? LOCKOUT : LOCKED, 16'hAAAA, 1'b1);
    ex(last ? LOCKOUT : LOCKED, last ? 16'hEEEE : 16'hFFFF, 1'b0);
    press(ENT);
  endtask

  task automatic exp_relock();
    ex(LOCKED, 16'hBBBB);
    ex(LOCKED, 16'hFFFF);
  endtask

  task automatic go_newpw();
    ex(NEWPW, 16'hBBBB);
    ex(NEWPW, 16'hFFFF);
    press(CHG);
  endtask

  task automatic wait_state(input logic [2:0] st, input int lim, input string nm);
    int n;
    n = 0;
    while (state_o != st && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state_o != st) begin
      fails++;
      $display("FAIL %s: state=%0d after %0d cycles, want %0d", nm, state_o, n, st);
    end
  endtask

  // Monitor: every change of the observable tuple must match the next queued event;
  // also checks how long CHECK and LOCKOUT last.
  initial begin
    logic [22:0] prev, cur, e;
    logic [2:0]  pst;
    int          run;
    wait (mon_en);
    prev = obs();
    pst  = state_o;
    run  = 1;
    forever begin
      @(negedge clk);
      cur = obs();
      if (state_o == pst) begin
        run++;
      end else begin
        if (pst == CHECK) begin
          checks++;
          if (run != 1) begin
            fails++;
            $display("FAIL check_len: %0d cycles, want 1", run);
          end
        end
        if (pst == LOCKOUT) begin
          checks++;
          if (run != LOCKOUT_CYC) begin
            fails++;
            $display("FAIL lockout_len: %0d cycles, want %0d", run, LOCKOUT_CYC);
          end
        end
        if (pst == OPEN) last_open_run = run;
        pst = state_o;
        run = 1;
      end
      if (cur != prev) begin
        checks++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got %s, nothing expected", fmt(cur));
        end else begin
          e = expq.pop_front();
          if (cur != e) begin
            fails++;
            $display("FAIL trace: got %s, want %s", fmt(cur), fmt(e));
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() != mk(LOCKED, 16'hFFFF, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL reset_state: got %s, want %s", fmt(obs()), fmt(mk(LOCKED, 16'hFFFF, 1'b0, 1'b0)));
    end
    mon_en = 1'b1;

    // Correct code opens; CLR relocks
    enter_ok(16'h1234);
    exp_relock();
    press(CLR);

    // Short entry is rejected but kept; 5th digit ignored
    ex(LOCKED, 16'hFFFA); press(5'd1);
    ex(LOCKED, 16'hFFAA); press(5'd2);
    ex(LOCKED, 16'hFFAA, 1'b1);
    ex(LOCKED, 16'hFFAA, 1'b0);
    press(ENT);
    ex(LOCKED, 16'hFAAA); press(5'd3);
    ex(LOCKED, 16'hAAAA); press(5'd4);
    press(5'd5);
    ex(CHECK, 16'hAAAA);
    ex(OPEN, 16'hAAAA);
    ex(OPEN, 16'hBBBB);
    press(ENT);
    exp_relock();
    press(CLR);

    // Three mismatches -> lockout; keys ignored; timed release clears fail count
    enter_bad(16'h1235, 1'b0);
    enter_bad(16'h1235, 1'b0);
    enter_bad(16'h1235, 1'b1);
    ex(LOCKED, 16'hEEEE);
    ex(LOCKED, 16'hFFFF);
    press(5'd1);
    press(ENT);
    wait_state(LOCKED, 200, "lockout_release");
    enter_bad(16'h1235, 1'b0);

    // Change password to 9876
    enter_ok(16'h1234);
    go_newpw();
    pw_digits(16'h9876, NEWPW);
    ex(CONFPW, 16'h9876);
    ex(CONFPW, 16'hFFFF);
    press(ENT);
    pw_digits(16'h9876, CONFPW);
    ex(LOCKED, 16'h9876, 1'b0, 1'b1);
    ex(LOCKED, 16'hFFFF, 1'b0, 1'b0);
    press(ENT);
    enter_ok(16'h9876);
    exp_relock();
    press(CLR);
    enter_bad(16'h1234, 1'b0);

    // Reset mid-entry restores the default password
    ex(LOCKED, 16'hFFFA); press(5'd1);
    ex(LOCKED, 16'hFFAA); press(5'd2);
    ex(LOCKED, 16'hFFFF);
    do_reset();
    enter_ok(16'h1234);

    // Confirmation mismatch returns to OPEN; OPEN relocks by itself
    go_newpw();
    pw_digits(16'h9876, NEWPW);
    ex(CONFPW, 16'h9876);
    ex(CONFPW, 16'hFFFF);
    press(ENT);
    pw_digits(16'h9870, CONFPW);
    ex(OPEN, 16'h9870, 1'b1);
    ex(OPEN, 16'hBBBB, 1'b0);
    press(ENT);
    exp_relock();
    wait_state(LOCKED, 600, "relock_after_confpw");
    enter_ok(16'h1234);
    exp_relock();
    wait_state(LOCKED, 600, "relock_idle");
    repeat (2) @(negedge clk);
    checks++;
    if (last_open_run != OPEN_CYC) begin
      fails++;
      $display("FAIL open_len: %0d cycles, want %0d", last_open_run, OPEN_CYC);
    end

    // Reset in CONFPW drops straight to LOCKED with the default password
    enter_ok(16'h1234);
    go_newpw();
    pw_digits(16'h5555, NEWPW);
    ex(CONFPW, 16'h5555);
    ex(CONFPW, 16'hFFFF);
    press(ENT);
    ex(CONFPW, 16'hFFF5); press(5'd5);
    ex(LOCKED, 16'hFFFF);
    do_reset();
    enter_ok(16'h1234);
    exp_relock();
    press(CLR);

    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL pending_events: %0d still queued, want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
